// File: rtl/elevator_ctrl_n_if.sv
// elevator_ctrl_n_if: button/request inputs and lamp/floor outputs of the elevator controller
interface elevator_ctrl_n_if #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3
);
    logic [FLOORS-1:0]  floor_req;
    logic               open_door_sig;
    logic               close_door_sig;
    logic [FLOOR_W-1:0] floor;
    logic [FLOORS-1:0]  req_pending;
    logic               up_lamp;
    logic               down_lamp;
    logic               door_open_lamp;
    logic               door_close_lamp;
    modport master (
        output floor_req, open_door_sig, close_door_sig,
        input  floor, req_pending, up_lamp, down_lamp, door_open_lamp, door_close_lamp
    );
    modport slave (
        input  floor_req, open_door_sig, close_door_sig,
        output floor, req_pending, up_lamp, down_lamp, door_open_lamp, door_close_lamp
    );
endinterface

// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: single-car SCAN elevator controller with tick-timed travel and door dwell
module elevator_ctrl_n #(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int TICK_DIV   = 100_000_000,
    parameter int RUN_TICKS  = 10,
    parameter int DOOR_TICKS = 5
) (
    input logic              clk,
    input logic              reset,
    elevator_ctrl_n_if.slave bus
);
    localparam int TW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int MAXT = RUN_TICKS > DOOR_TICKS ? RUN_TICKS : DOOR_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    typedef enum logic [1:0] {IDLE, DOOR_OPEN, MOVE_UP, MOVE_DOWN} state_t;
    typedef enum logic [1:0] {D_NONE, D_UP, D_DOWN} dir_t;
    state_t             state_q, state_d;
    dir_t               dir_q, dir_d, dec;
    logic [TW-1:0]      div_q;
    logic               tick, above, below, hold;
    logic [FLOOR_W-1:0] floor_q, floor_d, nf;
    logic [FLOORS-1:0]  pend_q, pend_d, clr, mask;
    logic [CW-1:0]      run_q, run_d, door_q, door_d;

    assign tick = div_q == TW'(TICK_DIV - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            state_q <= IDLE;
            dir_q   <= D_NONE;
            floor_q <= '0;
            pend_q  <= '0;
            run_q   <= '0;
            door_q  <= '0;
        end else begin
            div_q   <= tick ? '0 : div_q + TW'(1);
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            pend_q  <= pend_d;
            run_q   <= run_d;
            door_q  <= door_d;
        end
    end

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            above = above | (pend_q[i] & (FLOOR_W'(i) > floor_q));
            below = below | (pend_q[i] & (FLOOR_W'(i) < floor_q));
        end
        // keep heading up while work remains above; otherwise downward calls win
        dec = dir_q == D_UP ? (above ? D_UP : below ? D_DOWN : D_NONE)
                            : (below ? D_DOWN : above ? D_UP : D_NONE);
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        run_d   = run_q;
        door_d  = door_q;
        clr     = '0;
        nf      = state_q == MOVE_UP ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        hold    = bus.open_door_sig | bus.floor_req[floor_q];
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (pend_q[floor_q] || bus.open_door_sig) begin
                        state_d        = DOOR_OPEN;
                        door_d         = CW'(DOOR_TICKS);
                        clr[floor_q]   = 1'b1;
                    end else begin
                        dir_d = dec;
                        if (dec != D_NONE) begin
                            state_d = dec == D_UP ? MOVE_UP : MOVE_DOWN;
                            run_d   = CW'(RUN_TICKS);
                        end
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (run_q > CW'(1)) run_d = run_q - CW'(1);
                    else begin
                        floor_d = nf;
                        if (pend_q[nf] || nf == '0 || nf == FLOOR_W'(FLOORS - 1)) begin
                            state_d = DOOR_OPEN;
                            door_d  = CW'(DOOR_TICKS);
                            clr[nf] = 1'b1;
                        end else run_d = CW'(RUN_TICKS);
                    end
                end
                DOOR_OPEN: begin
                    if (bus.close_door_sig || door_q == CW'(1)) begin
                        dir_d   = dec;
                        state_d = dec == D_UP ? MOVE_UP : dec == D_DOWN ? MOVE_DOWN : IDLE;
                        run_d   = CW'(RUN_TICKS);
                    end else if (hold) door_d = CW'(DOOR_TICKS);
                    else door_d = door_q - CW'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // a call at the open landing only holds the door, and clearing beats a same-cycle set
    assign mask   = state_q == DOOR_OPEN ? FLOORS'(1) << floor_q : '0;
    assign pend_d = (pend_q | (bus.floor_req & ~mask)) & ~clr;

    assign bus.floor           = floor_q;
    assign bus.req_pending     = pend_q;
    assign bus.up_lamp         = !reset && state_q == MOVE_UP;
    assign bus.down_lamp       = !reset && state_q == MOVE_DOWN;
    assign bus.door_open_lamp  = !reset && state_q == DOOR_OPEN;
    assign bus.door_close_lamp = !reset && state_q != DOOR_OPEN;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed scenario checks of elevator_ctrl_n with FLOORS=8, TICK_DIV=1, RUN=3, DOOR=2
module tb_elevator_ctrl_n;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    elevator_ctrl_n_if #(.FLOORS(8), .FLOOR_W(3)) bus ();

    elevator_ctrl_n #(
        .FLOORS(8), .FLOOR_W(3), .TICK_DIV(1), .RUN_TICKS(3), .DOOR_TICKS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic wait_open(input logic level);
        for (int i = 0; i < 100 && bus.door_open_lamp !== level; i++) @(negedge clk);
        checks++;
        if (bus.door_open_lamp !== level) begin
            failures++;
            $display("FAIL wait_door_open got=%b exp=%b (timeout)", bus.door_open_lamp, level);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1;
        checks++; if (bus.floor !== 3'd0) begin failures++; $display("FAIL rst_floor got=%0d exp=0", bus.floor); end
        checks++; if (bus.req_pending !== 8'h00) begin failures++; $display("FAIL rst_pend got=%h exp=00", bus.req_pending); end
        checks++; if ({bus.up_lamp, bus.down_lamp, bus.door_open_lamp, bus.door_close_lamp} !== 4'b0000) begin
            failures++; $display("FAIL rst_lamps got=%b exp=0000", {bus.up_lamp, bus.down_lamp, bus.door_open_lamp, bus.door_close_lamp}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({bus.up_lamp, bus.down_lamp, bus.door_open_lamp, bus.door_close_lamp} !== 4'b0001) begin
            failures++; $display("FAIL rst_release_lamps got=%b exp=0001", {bus.up_lamp, bus.down_lamp, bus.door_open_lamp, bus.door_close_lamp}); end
    endtask

    task automatic test_single_call;
        bus.floor_req = 8'h08;
        @(negedge clk);
        bus.floor_req = 8'h00;
        checks++; if (bus.req_pending !== 8'h08) begin failures++; $display("FAIL call_latch got=%h exp=08", bus.req_pending); end
        checks++; if (bus.up_lamp !== 1'b0) begin failures++; $display("FAIL call_up_early got=%b exp=0", bus.up_lamp); end
        @(negedge clk);
        checks++; if (bus.up_lamp !== 1'b1) begin failures++; $display("FAIL call_up_start got=%b exp=1", bus.up_lamp); end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++; if (bus.floor !== 3'(k / 3)) begin failures++; $display("FAIL call_floor k=%0d got=%0d exp=%0d", k, bus.floor, k / 3); end
            checks++; if (bus.up_lamp !== (k < 9)) begin failures++; $display("FAIL call_up k=%0d got=%b exp=%b", k, bus.up_lamp, k < 9); end
        end
        checks++; if (bus.door_open_lamp !== 1'b1) begin failures++; $display("FAIL call_door got=%b exp=1", bus.door_open_lamp); end
        checks++; if (bus.req_pending !== 8'h00) begin failures++; $display("FAIL call_clear got=%h exp=00", bus.req_pending); end
        @(negedge clk);
        checks++; if (bus.door_open_lamp !== 1'b1) begin failures++; $display("FAIL call_dwell got=%b exp=1", bus.door_open_lamp); end
        @(negedge clk);
        checks++; if (bus.door_close_lamp !== 1'b1) begin failures++; $display("FAIL call_idle got=%b exp=1", bus.door_close_lamp); end
    endtask

    task automatic test_scan;
        bus.floor_req = 8'h20;
        @(negedge clk);
        bus.floor_req = 8'h00;
        for (int i = 0; i < 20 && !bus.up_lamp; i++) @(negedge clk);
        bus.floor_req = 8'h02;
        @(negedge clk);
        bus.floor_req = 8'h00;
        checks++; if (bus.req_pending !== 8'h22) begin failures++; $display("FAIL scan_pend got=%h exp=22", bus.req_pending); end
        wait_open(1'b1);
        checks++; if (bus.floor !== 3'd5) begin failures++; $display("FAIL scan_first got=%0d exp=5", bus.floor); end
        checks++; if (bus.req_pending !== 8'h02) begin failures++; $display("FAIL scan_pend5 got=%h exp=02", bus.req_pending); end
        wait_open(1'b0);
        checks++; if (bus.down_lamp !== 1'b1) begin failures++; $display("FAIL scan_reverse got=%b exp=1", bus.down_lamp); end
        wait_open(1'b1);
        checks++; if (bus.floor !== 3'd1) begin failures++; $display("FAIL scan_second got=%0d exp=1", bus.floor); end
        checks++; if (bus.req_pending !== 8'h00) begin failures++; $display("FAIL scan_pend_end got=%h exp=00", bus.req_pending); end
        wait_open(1'b0);
        checks++; if ({bus.up_lamp, bus.down_lamp} !== 2'b00) begin failures++; $display("FAIL scan_idle got=%b exp=00", {bus.up_lamp, bus.down_lamp}); end
    endtask

    task automatic test_door_buttons;
        bus.open_door_sig = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.door_open_lamp !== 1'b1) begin failures++; $display("FAIL hold_open i=%0d got=%b exp=1", i, bus.door_open_lamp); end
            @(negedge clk);
        end
        bus.floor_req = 8'h04;
        @(negedge clk);
        bus.floor_req = 8'h00;
        bus.open_door_sig = 1'b0;
        bus.close_door_sig = 1'b1;
        @(negedge clk);
        bus.close_door_sig = 1'b0;
        checks++; if (bus.up_lamp !== 1'b1) begin failures++; $display("FAIL close_move got=%b exp=1", bus.up_lamp); end
        checks++; if (bus.req_pending !== 8'h04) begin failures++; $display("FAIL close_pend got=%h exp=04", bus.req_pending); end
        wait_open(1'b1);
        checks++; if (bus.floor !== 3'd2) begin failures++; $display("FAIL close_arrive got=%0d exp=2", bus.floor); end
        bus.open_door_sig = 1'b1;
        bus.close_door_sig = 1'b1;
        @(negedge clk);
        bus.open_door_sig = 1'b0;
        bus.close_door_sig = 1'b0;
        checks++; if (bus.door_close_lamp !== 1'b1) begin failures++; $display("FAIL both_close got=%b exp=1", bus.door_close_lamp); end
    endtask

    task automatic test_same_floor;
        bus.floor_req = 8'h10;
        @(negedge clk);
        bus.floor_req = 8'h00;
        wait_open(1'b1);
        checks++; if (bus.floor !== 3'd4) begin failures++; $display("FAIL same_reach got=%0d exp=4", bus.floor); end
        wait_open(1'b0);
        bus.floor_req = 8'h10;
        @(negedge clk);
        bus.floor_req = 8'h00;
        checks++; if (bus.req_pending !== 8'h10) begin failures++; $display("FAIL same_latch got=%h exp=10", bus.req_pending); end
        @(negedge clk);
        checks++; if (bus.door_open_lamp !== 1'b1) begin failures++; $display("FAIL same_open got=%b exp=1", bus.door_open_lamp); end
        checks++; if (bus.req_pending !== 8'h00) begin failures++; $display("FAIL same_clear got=%h exp=00", bus.req_pending); end
        checks++; if ({bus.up_lamp, bus.down_lamp} !== 2'b00) begin failures++; $display("FAIL same_motion got=%b exp=00", {bus.up_lamp, bus.down_lamp}); end
        wait_open(1'b0);
    endtask

    task automatic test_async_reset;
        bus.floor_req = 8'h80;
        @(negedge clk);
        bus.floor_req = 8'h00;
        for (int i = 0; i < 50 && !(bus.floor == 3'd5 && bus.up_lamp); i++) @(negedge clk);
        checks++; if (!(bus.floor === 3'd5 && bus.up_lamp === 1'b1)) begin
            failures++; $display("FAIL arst_reach got floor=%0d up=%b exp floor=5 up=1", bus.floor, bus.up_lamp); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.floor !== 3'd0) begin failures++; $display("FAIL arst_floor got=%0d exp=0", bus.floor); end
        checks++; if (bus.req_pending !== 8'h00) begin failures++; $display("FAIL arst_pend got=%h exp=00", bus.req_pending); end
        checks++; if ({bus.up_lamp, bus.down_lamp, bus.door_open_lamp, bus.door_close_lamp} !== 4'b0000) begin
            failures++; $display("FAIL arst_lamps got=%b exp=0000", {bus.up_lamp, bus.down_lamp, bus.door_open_lamp, bus.door_close_lamp}); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({bus.up_lamp, bus.door_close_lamp} !== 2'b01) begin
            failures++; $display("FAIL arst_release got=%b exp=01", {bus.up_lamp, bus.door_close_lamp}); end
    endtask

    initial begin
        bus.floor_req = 8'h00;
        bus.open_door_sig = 1'b0;
        bus.close_door_sig = 1'b0;
        test_reset();
        test_single_call();
        test_scan();
        test_door_buttons();
        test_same_floor();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
